ps2_frame_deserializer: RTL and testbench

//   Parametrised serial-to-parallel deserializer for PS/2-style keyboard frames.
//   - Frame format: start, DATA_W data bits sent LSB first, optional parity, stop.
//   - Data is sampled only on edge_found strobes from the upstream edge detector.
//   - Checks start, parity and stop bits; a watchdog aborts frames that stall.
//   - Delivers a one-cycle valid pulse plus held code to the downstream decoder.

---
 rtl/ps2_frame_deserializer.sv | 97 +++++++++
 tb/tb_ps2_frame_deserializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_deserializer.sv
// ps2_frame_deserializer: PS/2-style frame deserializer with start/parity/stop checks and a stall watchdog.
module ps2_frame_deserializer #(
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 1,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              edge_found,
  input  logic              serial_data,
  output logic              valid_scan_code,
  output logic [DATA_W-1:0] scan_code_out,
  output logic              parity_err,
  output logic              frame_err,
  output logic              timeout_err
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_code_nxt;
  logic [BW-1:0]     r_cnt, w_cnt_nxt;
  logic [WW-1:0]     r_wd, w_wd_nxt;
  logic              r_par, w_par_nxt;
  logic              w_par_ok, w_expire;
  logic              w_valid_nxt, w_perr_nxt, w_ferr_nxt, w_terr_nxt;
  assign w_par_ok = (PARITY_EN == 0) || ((^r_shift ^ r_par) == (PARITY_ODD != 0));
  // An edge in the expiry cycle keeps the frame alive.
  assign w_expire = (r_state != IDLE) && !edge_found && (r_wd == WW'(TIMEOUT_CYC - 1));
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_code_nxt  = scan_code_out;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_terr_nxt  = 1'b0;
    w_wd_nxt    = (r_state == IDLE || edge_found) ? '0 : ((&r_wd) ? r_wd : r_wd + 1'b1);
    if (w_expire) begin
      w_state_nxt = IDLE;
      w_terr_nxt  = 1'b1;
      w_wd_nxt    = '0;
    end else if (edge_found) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = serial_data ? IDLE : DATA;
          w_cnt_nxt   = '0;
        end
        DATA: begin
          w_shift_nxt = (r_shift >> 1) | (DATA_W'(serial_data) << (DATA_W - 1));
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == BW'(DATA_W - 1)) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          w_par_nxt   = serial_data;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          w_ferr_nxt  = !serial_data;
          w_perr_nxt  = serial_data && !w_par_ok;
          w_valid_nxt = serial_data && w_par_ok;
          w_code_nxt  = (serial_data && w_par_ok) ? r_shift : scan_code_out;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_shift         <= '0;
      r_cnt           <= '0;
      r_wd            <= '0;
      r_par           <= 1'b0;
      scan_code_out   <= '0;
      valid_scan_code <= 1'b0;
      parity_err      <= 1'b0;
      frame_err       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_shift         <= w_shift_nxt;
      r_cnt           <= w_cnt_nxt;
      r_wd            <= w_wd_nxt;
      r_par           <= w_par_nxt;
      scan_code_out   <= w_code_nxt;
      valid_scan_code <= w_valid_nxt;
      parity_err      <= w_perr_nxt;
      frame_err       <= w_ferr_nxt;
      timeout_err     <= w_terr_nxt;
    end
  end
endmodule

// File: tb/tb_ps2_frame_deserializer.sv
// tb_ps2_frame_deserializer: directed and randomized frames checked against a frame-level reference model.
module tb_ps2_frame_deserializer;
  localparam int T0 = 10000;
  typedef bit bq_t[$];
  logic       clk = 1'b0, rst = 1'b0, e = 1'b0, d = 1'b1;
  logic       v0, p0, f0, t0, v1, p1, f1, t1;
  logic [7:0] c0;
  logic [8:0] c1;
  int checks = 0, errors = 0;
  int nv0 = 0, np0 = 0, nf0 = 0, nt0 = 0, nm0 = 0;
  int nv1 = 0, np1 = 0, nf1 = 0, nt1 = 0, nm1 = 0;
  always #5 clk = ~clk;
  ps2_frame_deserializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .TIMEOUT_CYC(T0)) u_dut0 (
    .clk(clk), .rst(rst), .edge_found(e), .serial_data(d), .valid_scan_code(v0),
    .scan_code_out(c0), .parity_err(p0), .frame_err(f0), .timeout_err(t0));
  ps2_frame_deserializer #(.DATA_W(9), .PARITY_EN(0), .PARITY_ODD(1), .TIMEOUT_CYC(T0)) u_dut1 (
    .clk(clk), .rst(rst), .edge_found(e), .serial_data(d), .valid_scan_code(v1),
    .scan_code_out(c1), .parity_err(p1), .frame_err(f1), .timeout_err(t1));
  always @(negedge clk) begin
    nv0 <= nv0 + int'(v0); np0 <= np0 + int'(p0); nf0 <= nf0 + int'(f0); nt0 <= nt0 + int'(t0);
    nv1 <= nv1 + int'(v1); np1 <= np1 + int'(p1); nf1 <= nf1 + int'(f1); nt1 <= nt1 + int'(t1);
    nm0 <= nm0 + int'((int'(v0) + int'(p0) + int'(f0) + int'(t0)) > 1);
    nm1 <= nm1 + int'((int'(v1) + int'(p1) + int'(f1) + int'(t1)) > 1);
  end
  function automatic bit odd_par(input int unsigned dat, input int w);
    bit x = 1'b0;
    for (int i = 0; i < w; i++) x ^= dat[i];
    return ~x;
  endfunction
  function automatic bq_t frame(input int unsigned dat, input int w, input bit pen, input bit par, input bit stop);
    bq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) q.push_back(dat[i]);
    if (pen) q.push_back(par);
    q.push_back(stop);
    return q;
  endfunction
  // 0 = good code, 1 = parity error, 2 = framing error (stop beats parity)
  function automatic int outcome(input int unsigned dat, input bit par, input bit stop);
    if (!stop) return 2;
    return (par == odd_par(dat, 8)) ? 0 : 1;
  endfunction
  task automatic send(input bq_t q, input int maxgap);
    @(negedge clk);
    foreach (q[i]) begin
      int g;
      e = 1'b1;
      d = q[i];
      @(negedge clk);
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        e = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    e = 1'b0;
    d = 1'b1;
  endtask
  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    if ({v0, p0, f0, t0, c0} !== 12'h0) begin
      errors++; $display("FAIL reset_dut0 got %h expected 000", {v0, p0, f0, t0, c0});
    end
    checks++;
    if ({v1, p1, f1, t1, c1} !== 13'h0) begin
      errors++; $display("FAIL reset_dut1 got %h expected 0000", {v1, p1, f1, t1, c1});
    end
    checks++;
    rst = 1'b1;
  endtask
  task automatic check_frame(input string name, input int unsigned dat, input bit par, input bit stop, input logic [7:0] exp_code);
    int bv = nv0, bp = np0, bf = nf0, bt = nt0, k;
    k = outcome(dat, par, stop);
    send(frame(dat, 8, 1'b1, par, stop), 0);
    settle();
    if (nv0 - bv !== int'(k == 0) || np0 - bp !== int'(k == 1) || nf0 - bf !== int'(k == 2) || nt0 - bt !== 0) begin
      errors++;
      $display("FAIL %s_pulses v=%0d p=%0d f=%0d t=%0d expected %0d/%0d/%0d/0", name,
               nv0 - bv, np0 - bp, nf0 - bf, nt0 - bt, int'(k == 0), int'(k == 1), int'(k == 2));
    end
    checks++;
    if (c0 !== exp_code) begin
      errors++; $display("FAIL %s_code got %h expected %h", name, c0, exp_code);
    end
    checks++;
  endtask
  task automatic test_good_frame();
    check_frame("good_1c", 32'h1C, 1'b0, 1'b1, 8'h1C);
  endtask
  task automatic test_parity_err();
    check_frame("parity_1c", 32'h1C, 1'b1, 1'b1, 8'h1C);
  endtask
  task automatic test_frame_err();
    check_frame("stop_f0", 32'hF0, 1'b1, 1'b0, 8'h1C);
  endtask
  task automatic test_timeout();
    bq_t q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int bt = nt0, bv = nv0, k = 0;
    send(q, 0);
    while (k < 2 * T0) begin
      @(negedge clk);
      k++;
      if (t0) break;
    end
    if (k !== T0) begin
      errors++; $display("FAIL timeout_latency got %0d idle cycles expected %0d", k, T0);
    end
    checks++;
    settle();
    if (nt0 - bt !== 1 || nv0 - bv !== 0) begin
      errors++; $display("FAIL timeout_pulses t=%0d v=%0d expected 1/0", nt0 - bt, nv0 - bv);
    end
    checks++;
    check_frame("after_to_f0", 32'hF0, odd_par(32'hF0, 8), 1'b1, 8'hF0);
  endtask
  task automatic test_reset_mid_frame();
    bq_t q = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int bv = nv0, bp = np0, bf = nf0, bt = nt0;
    send(q, 0);
    @(negedge clk);
    e = 1'b1; d = 1'b1; rst = 1'b0;
    @(negedge clk);
    e = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if ({v0, p0, f0, t0, c0} !== 12'h0 || nv0 + np0 + nf0 + nt0 - bv - bp - bf - bt !== 0) begin
      errors++; $display("FAIL reset_mid got %h pulses=%0d expected 000/0", {v0, p0, f0, t0, c0},
                         nv0 + np0 + nf0 + nt0 - bv - bp - bf - bt);
    end
    checks++;
    rst = 1'b1;
    check_frame("after_rst_5a", 32'h5A, odd_par(32'h5A, 8), 1'b1, 8'h5A);
  endtask
  task automatic test_random();
    logic [7:0] exp_code = c0;
    for (int n = 0; n < 40; n++) begin
      int unsigned dat = $urandom_range(255);
      int unsigned r = $urandom_range(9);
      bit par = odd_par(dat, 8) ^ (r == 0);
      bit stop = (r != 1);
      int bv = nv0, bp = np0, bf = nf0, bt = nt0, k;
      k = outcome(dat, par, stop);
      if (k == 0) exp_code = dat[7:0];
      send(frame(dat, 8, 1'b1, par, stop), 2);
      settle();
      if (nv0 - bv !== int'(k == 0) || np0 - bp !== int'(k == 1) || nf0 - bf !== int'(k == 2) || nt0 - bt !== 0) begin
        errors++;
        $display("FAIL rand%0d_pulses dat=%h v=%0d p=%0d f=%0d t=%0d expected outcome %0d", n, dat,
                 nv0 - bv, np0 - bp, nf0 - bf, nt0 - bt, k);
      end
      checks++;
      if (c0 !== exp_code) begin
        errors++; $display("FAIL rand%0d_code got %h expected %h", n, c0, exp_code);
      end
      checks++;
    end
  endtask
  task automatic test_back_to_back();
    bq_t q = frame(32'h33, 8, 1'b1, odd_par(32'h33, 8), 1'b1);
    bq_t q2 = frame(32'hC4, 8, 1'b1, odd_par(32'hC4, 8), 1'b1);
    int bv = nv0;
    foreach (q2[i]) q.push_back(q2[i]);
    send(q, 0);
    settle();
    if (nv0 - bv !== 2) begin
      errors++; $display("FAIL b2b_valid got %0d expected 2", nv0 - bv);
    end
    checks++;
    if (c0 !== 8'hC4) begin
      errors++; $display("FAIL b2b_code got %h expected c4", c0);
    end
    checks++;
  endtask
  task automatic test_wide_no_parity();
    int bv, bp, bf, bt;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    bv = nv1; bp = np1; bf = nf1; bt = nt1;
    send(frame(32'h1A5, 9, 1'b0, 1'b0, 1'b1), 0);
    settle();
    if (nv1 - bv !== 1 || np1 - bp !== 0 || nf1 - bf !== 0 || nt1 - bt !== 0) begin
      errors++; $display("FAIL w9_pulses v=%0d p=%0d f=%0d t=%0d expected 1/0/0/0", nv1 - bv, np1 - bp, nf1 - bf, nt1 - bt);
    end
    checks++;
    if (c1 !== 9'h1A5) begin
      errors++; $display("FAIL w9_code got %h expected 1a5", c1);
    end
    checks++;
  endtask
  task automatic test_stray_edge();
    int b0 = nv0 + np0 + nf0 + nt0, b1 = nv1 + np1 + nf1 + nt1;
    bq_t q = {1'b1};
    send(q, 0);
    repeat (5) @(negedge clk);
    #1;
    if (nv0 + np0 + nf0 + nt0 - b0 !== 0 || nv1 + np1 + nf1 + nt1 - b1 !== 0) begin
      errors++; $display("FAIL stray_pulses got %0d/%0d expected 0/0", nv0 + np0 + nf0 + nt0 - b0, nv1 + np1 + nf1 + nt1 - b1);
    end
    checks++;
    if (c1 !== 9'h1A5) begin
      errors++; $display("FAIL stray_code got %h expected 1a5", c1);
    end
    checks++;
    send(frame(32'h0F3, 9, 1'b0, 1'b0, 1'b1), 1);
    settle();
    if (c1 !== 9'h0F3) begin
      errors++; $display("FAIL after_stray_code got %h expected 0f3", c1);
    end
    checks++;
  endtask
  task automatic test_exclusive();
    if (nm0 + nm1 !== 0) begin
      errors++; $display("FAIL exclusive_pulses got %0d overlapping cycles expected 0", nm0 + nm1);
    end
    checks++;
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    test_wide_no_parity();
    test_stray_edge();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
